// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared types and helpers for the four-requester round-robin arbiter.
package rr_mux4_arbiter_pkg;

    localparam int NREQ             = 4;
    localparam int DEFAULT_WIDTH    = 32;
    localparam int DEFAULT_MAX_LOCK = 8;
    localparam int DEFAULT_CNT_W    = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Result of one round-robin scan: whether anyone won, and who.
    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } arb_pick_t;

    // Scan requesters starting at ptr and wrapping; the first active one wins.
    function automatic arb_pick_t arb_pick(input logic [NREQ-1:0] req,
                                           input logic [1:0]      ptr);
        arb_pick_t  res;
        logic [1:0] cand;
        res = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = ptr + 2'(i);
            if (!res.found && req[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

    // Expand a requester index into its one-hot mask.
    function automatic logic [NREQ-1:0] to_onehot(input logic [1:0] sel);
        return 4'(1) << sel;
    endfunction

endpackage

// File: rtl/rr_mux4_arbiter_mux.sv
// Plain 4:1 datapath multiplexer; the arbiter drives its select.
module Mux_4to1 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);

    // Route the selected word straight through, no storage.
    always_comb begin
        y = d0;
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            2'd3:    y = d3;
            default: y = d0;
        endcase
    end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter sharing one valid/ready output channel among four
// requesters, with lockable bursts that are force-released after MAX_LOCK beats.
module rr_mux4_arbiter
    import rr_mux4_arbiter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int MAX_LOCK = DEFAULT_MAX_LOCK,
    parameter int CNT_W    = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [3:0]       lock,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       select,
    output logic [3:0]       grant,
    output logic [3:0]       ack,
    output logic             busy
);

    // Last beat index a locked requester may reach before it must let go.
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(MAX_LOCK - 1);

    arb_state_t       state_q, state_d;
    logic [1:0]       select_q, select_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    arb_pick_t        pick;
    logic             hs;

    assign out_valid = (state_q == GRANT);
    assign busy      = (state_q == GRANT);
    assign select    = select_q;
    assign hs        = out_valid & out_ready;
    assign grant     = out_valid ? to_onehot(select_q) : 4'b0000;
    assign ack       = hs ? to_onehot(select_q) : 4'b0000;

    Mux_4to1 #(
        .WIDTH(WIDTH)
    ) u_mux (
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .d3  (d3),
        .sel (select_q),
        .y   (out_data)
    );

    // Next-state logic: grant from idle, extend locked bursts, or rotate on handshake.
    always_comb begin
        state_d  = state_q;
        select_d = select_q;
        ptr_d    = ptr_q;
        beat_d   = beat_q;
        pick     = '0;
        case (state_q)
            IDLE: begin
                pick = arb_pick(req, ptr_q);
                if (pick.found) begin
                    select_d = pick.idx;
                    beat_d   = '0;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                if (hs) begin
                    if (lock[select_q] && (beat_q < LOCK_LAST)) begin
                        beat_d = beat_q + 1'b1;
                    end else begin
                        ptr_d = select_q + 2'd1;
                        pick  = arb_pick(req, ptr_d);
                        if (pick.found) begin
                            select_d = pick.idx;
                            beat_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            select_q <= '0;
            ptr_q    <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
            ptr_q    <= ptr_d;
            beat_q   <= beat_d;
        end
    end

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed bench for rr_mux4_arbiter: a vector table plus hand sequences
// for locked bursts, stalls and reset in the middle of a burst.
module tb_rr_mux4_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] d0, d1, d2, d3;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  select;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] dv [4];

    typedef struct packed {
        logic       rst;
        logic [3:0] req;
        logic [3:0] lock;
        logic       rdy;
        logic       exp_valid;
        logic [1:0] exp_sel;
        logic [3:0] exp_ack;
    } vec_t;

    vec_t vecs [17];

    rr_mux4_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .lock      (lock),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .select    (select),
        .grant     (grant),
        .ack       (ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // A granted requester must keep req high until its word is acknowledged.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && req[select] === 1'b0 && ack[select] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL protocol: req[%0d] dropped while granted without ack", select);
        end
    end

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                                input logic rdy, input logic ev, input logic [1:0] es,
                                input logic [3:0] ea);
        vec_t v;
        v.rst = r; v.req = rq; v.lock = lk; v.rdy = rdy;
        v.exp_valid = ev; v.exp_sel = es; v.exp_ack = ea;
        return v;
    endfunction

    // Advance one clock, then drive the inputs for the new cycle and wait for mid-cycle.
    task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                                 input logic rdy);
        @(posedge clk);
        #1;
        rst = r; req = rq; lock = lk; out_ready = rdy;
        @(negedge clk);
    endtask

    task automatic cmp(input string what, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", what, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic ev, input logic [1:0] es,
                               input logic [3:0] ea);
        logic [3:0] eg;
        eg = ev ? (4'b0001 << es) : 4'b0000;
        cmp({name, " out_valid"}, 32'(out_valid), 32'(ev));
        cmp({name, " busy"},      32'(busy),      32'(ev));
        cmp({name, " select"},    32'(select),    32'(es));
        cmp({name, " grant"},     32'(grant),     32'(eg));
        cmp({name, " ack"},       32'(ack),       32'(ea));
        if (ev) cmp({name, " out_data"}, out_data, dv[es]);
    endtask

    initial begin
        dv[0] = 32'h1111_0000; dv[1] = 32'h2222_1111;
        dv[2] = 32'hDEAD_BEEF; dv[3] = 32'h4444_3333;
        d0 = dv[0]; d1 = dv[1]; d2 = dv[2]; d3 = dv[3];
        rst = 1'b1; req = 4'b0000; lock = 4'b0000; out_ready = 1'b0;

        // reset, single grant to 2, wrap-around from ptr=3, fairness from reset
        vecs[0]  = mk(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000);
        vecs[1]  = mk(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000);
        vecs[2]  = mk(1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000);
        vecs[3]  = mk(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0100);
        vecs[4]  = mk(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000);
        vecs[5]  = mk(1'b0, 4'b0101, 4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000);
        vecs[6]  = mk(1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b0001);
        vecs[7]  = mk(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0100);
        vecs[8]  = mk(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000);
        vecs[9]  = mk(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000);
        vecs[10] = mk(1'b0, 4'b1111, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000);
        vecs[11] = mk(1'b0, 4'b1111, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b0001);
        vecs[12] = mk(1'b0, 4'b1111, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b0010);
        vecs[13] = mk(1'b0, 4'b1111, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0100);
        vecs[14] = mk(1'b0, 4'b1111, 4'b0000, 1'b1, 1'b1, 2'd3, 4'b1000);
        vecs[15] = mk(1'b0, 4'b1111, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b0001);
        vecs[16] = mk(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0000);

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].lock, vecs[i].rdy);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_sel, vecs[i].exp_ack);
        end

        // locked burst on requester 0: eight beats, then forced release to 1
        applyStimulus(1'b0, 4'b0011, 4'b0001, 1'b1);
        checkOutput("lock idle", 1'b0, 2'd0, 4'b0000);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 4'b0011, 4'b0001, 1'b1);
            checkOutput($sformatf("lock beat%0d", k), 1'b1, 2'd0, 4'b0001);
        end
        applyStimulus(1'b0, 4'b0011, 4'b0001, 1'b1);
        checkOutput("lock release", 1'b1, 2'd1, 4'b0010);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1);
        checkOutput("lock after", 1'b1, 2'd0, 4'b0001);

        // stall on requester 1 while requester 3 arrives
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
        checkOutput("stall rst", 1'b0, 2'd0, 4'b0000);
        applyStimulus(1'b0, 4'b0010, 4'b0000, 1'b0);
        checkOutput("stall idle", 1'b0, 2'd0, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, (k >= 2) ? 4'b1010 : 4'b0010, 4'b0000, 1'b0);
            checkOutput($sformatf("stall%0d", k), 1'b1, 2'd1, 4'b0000);
        end
        applyStimulus(1'b0, 4'b1000, 4'b0000, 1'b1);
        checkOutput("stall ack1", 1'b1, 2'd1, 4'b0010);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1);
        checkOutput("stall ack3", 1'b1, 2'd3, 4'b1000);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
        checkOutput("stall done", 1'b0, 2'd3, 4'b0000);

        // reset at beat 3 of a locked burst on requester 2 (ptr would be 3 without reset)
        applyStimulus(1'b0, 4'b0010, 4'b0000, 1'b1);
        checkOutput("rb idle", 1'b0, 2'd3, 4'b0000);
        applyStimulus(1'b0, 4'b0100, 4'b0000, 1'b1);
        checkOutput("rb g1", 1'b1, 2'd1, 4'b0010);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 4'b0100, 4'b0100, 1'b1);
            checkOutput($sformatf("rb beat%0d", k), 1'b1, 2'd2, 4'b0100);
        end
        applyStimulus(1'b1, 4'b0100, 4'b0100, 1'b0);
        checkOutput("rb rst", 1'b1, 2'd2, 4'b0000);
        applyStimulus(1'b0, 4'b1001, 4'b0000, 1'b1);
        checkOutput("rb post", 1'b0, 2'd0, 4'b0000);
        applyStimulus(1'b0, 4'b1000, 4'b0000, 1'b1);
        checkOutput("rb g0", 1'b1, 2'd0, 4'b0001);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1);
        checkOutput("rb g3", 1'b1, 2'd3, 4'b1000);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
        checkOutput("rb done", 1'b0, 2'd3, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
